// File: rtl/inst_enc_if.sv
// Request/response bundle for the inst_enc instruction encoder.
// The master modport is the requester/consumer; the slave modport is the encoder.
interface inst_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [63:0] imm;
  logic [4:0]  rn;
  logic [4:0]  rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        ovf;
  logic        err;
  logic [7:0]  ovf_count;

  modport master (
    output in_valid, op, imm, rn, rt, out_ready,
    input  in_ready, out_valid, instr, ovf, err, ovf_count
  );

  modport slave (
    input  in_valid, op, imm, rn, rt, out_ready,
    output in_ready, out_valid, instr, ovf, err, ovf_count
  );
endinterface

// File: rtl/inst_enc.sv
// LDUR/STUR/CBZ encoder with a 2-entry result FIFO and a saturating overflow counter.
// Define INST_ENC_SAT_EN to clamp out-of-range immediates instead of truncating them.
module inst_enc (
  input  logic       clk,
  input  logic       reset,
  inst_enc_if.slave  bus
);
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  // Handshake: a request transfers on a rising edge with in_valid && in_ready;
  // a word transfers on a rising edge with out_valid && out_ready. Held words
  // stay stable until taken, and in_ready never depends on a same-cycle pop.

  logic        ovf9;
  logic        ovf19;
  logic [8:0]  field9;
  logic [18:0] field19;
  logic [31:0] enc_instr;
  logic        enc_ovf;
  logic        enc_err;

  assign ovf9  = (bus.imm[63:8]  != {56{bus.imm[8]}});
  assign ovf19 = (bus.imm[63:18] != {46{bus.imm[18]}});

`ifdef INST_ENC_SAT_EN
  // Clamp toward the sign of the full 64-bit value.
  assign field9  = ovf9  ? (bus.imm[63] ? 9'h100   : 9'h0ff)   : bus.imm[8:0];
  assign field19 = ovf19 ? (bus.imm[63] ? 19'h40000 : 19'h3ffff) : bus.imm[18:0];
`else
  assign field9  = bus.imm[8:0];
  assign field19 = bus.imm[18:0];
`endif

  always_comb begin
    enc_instr = '0;
    enc_ovf   = 1'b0;
    enc_err   = 1'b0;
    case (bus.op)
      2'b00: begin
        enc_instr = {OPC_LDUR, field9, 2'b00, bus.rn, bus.rt};
        enc_ovf   = ovf9;
      end
      2'b01: begin
        enc_instr = {OPC_STUR, field9, 2'b00, bus.rn, bus.rt};
        enc_ovf   = ovf9;
      end
      2'b10: begin
        enc_instr = {OPC_CBZ, field19, bus.rt};
        enc_ovf   = ovf19;
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  logic [1:0][33:0] mem;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             ready_en;
  logic             push;
  logic             pop;
  logic [33:0]      head;
  logic [7:0]       ovf_cnt;

  assign head         = mem[rd_ptr];
  assign bus.out_valid = (count != 2'd0);
  assign bus.in_ready  = ready_en && (count != 2'd2);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;

  assign bus.instr     = bus.out_valid ? head[33:2] : 32'h0;
  assign bus.ovf       = bus.out_valid ? head[1]    : 1'b0;
  assign bus.err       = bus.out_valid ? head[0]    : 1'b0;
  assign bus.ovf_count = ovf_cnt;

  // ready_en keeps in_ready low through reset and for the release cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {enc_instr, enc_ovf, enc_err};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt <= 8'd0;
    end else if (pop && head[1] && (ovf_cnt != 8'hff)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_inst_enc.sv
// Self-checking bench for inst_enc: directed cases, randomized traffic and
// an abstract reference model feeding a scoreboard queue.
module tb_inst_enc;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_cnt;
  logic [33:0] exp_q[$];

  inst_enc_if bus ();

  inst_enc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: range test and field packing done with plain integer arithmetic.
  function automatic logic [33:0] model(input logic [1:0] o, input logic [63:0] i,
                                        input logic [4:0] n, input logic [4:0] t);
    longint v, lo, hi, span, field, word, base;
    logic of;
    logic [63:0] w;
    if (o == 2'b11) return {32'h0, 1'b0, 1'b1};
    v = $signed(i);
    if (o == 2'b10) begin
      lo = -262144; hi = 262143; span = 524288;
    end else begin
      lo = -256; hi = 255; span = 512;
    end
    of = (v < lo) || (v > hi);
`ifdef INST_ENC_SAT_EN
    if (v < lo) v = lo;
    else if (v > hi) v = hi;
`endif
    field = ((v % span) + span) % span;
    if (o == 2'b10) begin
      base = 180;
      word = base * 16777216 + field * 32 + longint'(t);
    end else begin
      base = (o == 2'b00) ? 1986 : 1984;
      word = base * 2097152 + field * 4096 + longint'(n) * 32 + longint'(t);
    end
    w = word;
    return {w[31:0], of, 1'b0};
  endfunction

  task automatic send(input logic [1:0] o, input logic [63:0] i, input logic [4:0] n,
                      input logic [4:0] t, input bit rnd);
    bit done;
    int k;
    bus.op = o; bus.imm = i; bus.rn = n; bus.rt = t;
    bus.in_valid = 1'b1;
    done = 0;
    k = 0;
    while (!done && k < 200) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(o, i, n, t));
        done = 1;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 200 cycles");
    end
  endtask

  task automatic drain();
    int k;
    bus.out_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Latency-1 check against a constant word from an empty FIFO.
  task automatic direct(input logic [1:0] o, input logic [63:0] i, input logic [4:0] n,
                        input logic [4:0] t, input logic [31:0] ei, input logic eo, input logic ee);
    bus.out_ready = 1'b1;
    send(o, i, n, t, 0);
    @(negedge clk);
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_instr", bus.instr, ei);
    chk("lat_ovf", bus.ovf, eo);
    chk("lat_err", bus.err, ee);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    logic [33:0] h;
    if (reset) begin
      chk("ovf_count", bus.ovf_count, exp_cnt);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected no word", bus.instr);
        end else begin
          chk("word", {bus.instr, bus.ovf, bus.err}, exp_q[0]);
          if (bus.out_ready) begin
            h = exp_q.pop_front();
            if (h[1] && exp_cnt != 255) exp_cnt++;
          end
        end
      end else begin
        chk("idle_zero", {bus.instr, bus.ovf, bus.err}, 0);
      end
    end
  end

  initial begin
    longint lo, hi, span, v;
    logic [1:0] o;
    checks = 0; errors = 0; exp_cnt = 0;
    bus.in_valid = 1'b0; bus.op = 2'b00; bus.imm = '0; bus.rn = '0; bus.rt = '0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_ovf_count", bus.ovf_count, 0);
    #21 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    direct(2'b00, 64'd15, 5'd0, 5'd0, 32'hF840F000, 1'b0, 1'b0);
    direct(2'b00, -64'sd15, 5'd0, 5'd0, 32'hF85F1000, 1'b0, 1'b0);
    direct(2'b10, 64'd31, 5'd0, 5'd0, 32'hB40003E0, 1'b0, 1'b0);
`ifdef INST_ENC_SAT_EN
    direct(2'b10, 64'd262144, 5'd0, 5'd0, 32'hB47FFFE0, 1'b1, 1'b0);
`else
    direct(2'b10, 64'd262144, 5'd0, 5'd0, 32'hB4800000, 1'b1, 1'b0);
`endif
    drain();
    @(negedge clk);
    chk("ovf_count_one", bus.ovf_count, 1);
    @(posedge clk); #1;
    direct(2'b11, {$urandom, $urandom}, 5'd3, 5'd9, 32'h0, 1'b0, 1'b1);
    direct(2'b01, 64'd255, 5'd7, 5'd31, 32'hF80FF0FF, 1'b0, 1'b0);
    drain();

    // Backpressure: two fill the FIFO, the third waits for a pop.
    bus.out_ready = 1'b0;
    send(2'b00, 64'd1, 5'd1, 5'd2, 0);
    send(2'b01, 64'd2, 5'd3, 5'd4, 0);
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    fork
      send(2'b10, 64'd3, 5'd0, 5'd5, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("held_in_ready", bus.in_ready, 0);
          chk("held_valid", bus.out_valid, 1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    for (int n = 0; n < 600; n++) begin
      o = 2'($urandom_range(0, 3));
      if (o == 2'b10) begin lo = -262144; hi = 262143; span = 524288; end
      else begin lo = -256; hi = 255; span = 512; end
      case ($urandom_range(0, 3))
        0: v = longint'($urandom_range(0, 32'(hi - lo))) + lo;
        1: case ($urandom_range(0, 3))
             0: v = lo;
             1: v = hi;
             2: v = lo - 1;
             default: v = hi + 1;
           endcase
        2: v = {$urandom, $urandom};
        default: v = longint'($urandom_range(0, 32'(4 * span))) - 2 * span;
      endcase
      send(o, v, 5'($urandom), 5'($urandom), 1);
      repeat ($urandom_range(0, 2)) begin
        bus.out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
    end
    drain();
    @(negedge clk);
    chk("ovf_count_sat", bus.ovf_count, exp_cnt);
    @(posedge clk); #1;

    // Reset with two words buffered.
    bus.out_ready = 1'b0;
    send(2'b10, 64'h1_0000_0000, 5'd0, 5'd1, 0);
    send(2'b00, 64'd4, 5'd2, 5'd3, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_ovf_count", bus.ovf_count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_instr", bus.instr, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("release_in_ready_pre", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    direct(2'b00, 64'd15, 5'd0, 5'd0, 32'hF840F000, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
